// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined signed adder/subtractor.
// Holds the op encoding and the stage-count helper.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int stages(input int n, input int seg);
    return n / seg;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// SEG-bit combinational ripple-carry adder, one per pipeline stage.
// Ports: a, b operands; ci carry-in; s sum; co carry-out.
module addsub_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[SEG];

endmodule

// File: rtl/addsub_pipe_ody.sv
// Pipelined signed add/sub: N-bit carry chain cut into SEG-bit stages.
// Ports: clk, reset (sync, high); in_valid/in_ready + x, y, c_in, sub;
// out_valid/out_ready + sum (N+1 bits), c_out, ovf.
module addsub_pipe_ody
  import addsub_pkg::*;
#(
  parameter int N   = 8,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int STAGES = stages(N, SEG);

  if ((N < 2) || (SEG < 1) || ((N % SEG) != 0)) begin : g_bad
    $error("addsub_pipe_ody: N must be >= 2 and a multiple of SEG");
  end

  // xs/ys: operand bits not yet consumed, sign-extended down as they
  // are used so the final stage finds only sign copies left.
  // lo: sum bits already produced by earlier segments.
  typedef struct packed {
    logic         v;
    logic [N-1:0] xs;
    logic [N-1:0] ys;
    logic [N-1:0] lo;
    logic         c;
  } stage_t;

  logic         en;
  logic [N-1:0] yy;
  logic         cc;
  stage_t       head;
  stage_t       last;

  always_comb begin
    yy = y;
    cc = c_in;
    unique case (sub)
      OP_ADD: begin
        yy = y;
        cc = c_in;
      end
      OP_SUB: begin
        yy = ~y;
        cc = 1'b1;
      end
    endcase
  end

  assign en = !out_valid || out_ready;
  assign in_ready = en;

  assign head = '{v: in_valid, xs: x, ys: yy, lo: '0, c: cc};

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t         d;
    stage_t         nx;
    stage_t         q;
    logic [SEG-1:0] s;
    logic           co;

    if (k == 0) begin : g_head
      assign d = head;
    end else begin : g_tail
      assign d = g_st[k-1].q;
    end

    addsub_seg #(.SEG(SEG)) u_seg (
      .a  (d.xs[SEG-1:0]),
      .b  (d.ys[SEG-1:0]),
      .ci (d.c),
      .s  (s),
      .co (co)
    );

    always_comb begin
      nx    = d;
      nx.xs = N'($signed(d.xs) >>> SEG);
      nx.ys = N'($signed(d.ys) >>> SEG);
      nx.lo = d.lo | (N'(s) << (k * SEG));
      nx.c  = co;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        q <= '0;
      end else if (en) begin
        q <= nx;
      end
    end
  end

  assign last = g_st[STAGES-1].q;

  // Only sign copies remain in xs/ys, so an OR recovers each sign.
  assign out_valid = last.v;
  assign c_out     = last.c;
  assign sum       = {(|last.xs) ^ (|last.ys) ^ last.c, last.lo};
  assign ovf       = sum[N] ^ sum[N-1];

endmodule
